sd_widen_c: RTL
===============

Name: sd_widen_c

Overview:
- Srdy/drdy width-up converter that consumes the narrow byte stream leaving an sd_fifo_c output port.
- Packs `ratio` consecutive narrow beats into one wide word, with a per-lane valid mask.
- `c_last` closes a packet early, so partial words are emitted.
- Sits directly downstream of sd_fifo_c, between the FIFO and wide-datapath consumers.

Parameters:
- width, 8, narrow beat width in bits; must match the upstream FIFO width.
- ratio, 4, narrow beats per wide word; ratio >= 1.
- lw, $clog2(ratio) (minimum 1), lane index width; derived, not overridable.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- c_srdy  input  1  narrow beat valid.
- c_drdy  output  1  narrow beat accepted.
- c_data  input  width  narrow beat payload.
- c_last  input  1  beat is the final beat of a packet; qualified by c_srdy.
- p_srdy  output  1  wide word valid.
- p_drdy  input  1  wide word accepted.
- p_data  output  width*ratio  wide word; lane k = bits [k*width +: width]; lane 0 carries the first beat.
- p_valid  output  ratio  lane valid mask; bits are contiguous from bit 0.
- p_last  output  1  wide word ends a packet.

Behaviour:
- Reset:
  - p_srdy=0, p_data=0, p_valid=0, p_last=0.
  - Lane index idx=0, accumulator data and mask = 0.
  - c_drdy=1 once reset deasserts.
- Transfer: occurs on any edge where srdy&drdy; both sides follow standard srdy/drdy rules.
- c_drdy = !p_srdy || p_drdy:
  - Purely a function of output-register state and p_drdy.
  - No combinational path from c_srdy, c_data or c_last.
- Non-completing input transfer (idx != ratio-1 and c_last=0):
  - acc lane idx <= c_data; mask[idx] <= 1; idx <= idx+1.
- Completing input transfer (idx == ratio-1 or c_last=1):
  - p_data <= acc merged with c_data at lane idx; unfilled lanes = 0.
  - p_valid <= mask | (1<<idx); p_last <= c_last; p_srdy <= 1.
  - acc, mask and idx cleared to 0.
- Output transfer with no completing input in the same cycle: p_srdy <= 0. p_data, p_valid and p_last hold their values (don't-care while p_srdy=0).
- Simultaneous output transfer and completing input: new word loaded and p_srdy stays 1. This gives full throughput: one wide word per `ratio` clocks when p_drdy is held high.
- Latency: the completing beat's edge raises p_srdy in the following cycle.
- Backpressure: with p_srdy=1 and p_drdy=0, c_drdy=0. No input beat (partial or completing) is accepted until the word drains.
- c_last on lane 0: one-lane word, p_valid=...0001, p_last=1.
- ratio=1: every beat completes; the block behaves as a 1-deep registered stage with p_valid=1 and p_last=c_last.
- idx wrap: idx never exceeds ratio-1; the completing transfer resets it to 0.
- No time-based flush: a partial word waits indefinitely for further beats or c_last.
- Reset mid-packet: partial accumulator contents and any pending output word are discarded. Output restarts at lane 0 with no stale mask bits.
- Assertions:
  - Flag c_data changing while c_srdy=1 and c_drdy=0.
  - Flag p_valid not of the form 2^n-1 when p_srdy=1.

Decomposition:
- Shared sd package:
  - lane-index width function: clog2 clamped to minimum 1.
  - lane slice helper.
  - Reused by a future sd_narrow_c (wide-to-narrow counterpart).
- No sub-module. Accumulator and output register are a single flat block; the output stage is not split into a separate instance because c_drdy depends on its state.

Test Plan:
- Gen (incrementing bytes from 0x00), chk, srdy_pat=drdy_pat=0xFF, ratio=4, no c_last:
  - First word 0x03020100 with p_valid=4'hF, p_last=0.
  - One word every 4 clocks; 1000 bytes -> 250 words, all in order.
- c_last asserted on every 3rd beat, ratio=4:
  - Words 0x00020100 (p_valid=4'h7, p_last=1), then 0x00050403 (p_valid=4'h7, p_last=1), and so on.
  - Unfilled lane is zero.
- c_last on a lone beat 0xAA with idx=0:
  - Next cycle p_srdy=1, p_data=0x000000AA, p_valid=4'h1, p_last=1.
- Backpressure, chk drdy_pat=0x03, gen srdy_pat=0xFD:
  - c_drdy low whenever a word waits with p_drdy=0.
  - No byte lost or duplicated; ok count reaches 250 words.
- Reset pulse after 2 beats of a word (0x10, 0x11), then send 0x20..0x23:
  - First word after reset is 0x23222120 with p_valid=4'hF; no 0x10/0x11 remnant.
- ratio=1 build, width=8:
  - Output equals input sequence with 1-cycle latency, p_valid=1.
  - Full rate with drdy_pat=0xFF; correct stalls with drdy_pat=0xA5.

Source files
------------

// File: rtl/sd_widen_c_pkg.sv
// Shared helpers for the srdy/drdy width converters (sd_widen_c, sd_narrow_c).
package sd_widen_c_pkg;

    // Lane index width: clog2 of the lane count, never narrower than one bit.
    function automatic int sd_lane_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

    // Bit offset of a lane within a wide word whose lanes are lane_width bits.
    function automatic int sd_lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

endpackage

// File: rtl/sd_widen_c.sv
// Narrow-to-wide srdy/drdy converter: packs `ratio` beats into one wide word
// with a contiguous lane-valid mask. c_last closes a word early.
module sd_widen_c
    import sd_widen_c_pkg::*;
#(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     c_srdy,
    output logic                     c_drdy,
    input  logic [width-1:0]         c_data,
    input  logic                     c_last,
    output logic                     p_srdy,
    input  logic                     p_drdy,
    output logic [width*ratio-1:0]   p_data,
    output logic [ratio-1:0]         p_valid,
    output logic                     p_last
);

    localparam int            lw       = sd_lane_w(ratio);
    localparam logic [lw-1:0] last_idx = lw'(ratio - 1);

    logic [lw-1:0]          idx;
    logic [width*ratio-1:0] acc;
    logic [ratio-1:0]       mask;
    logic [width*ratio-1:0] merged_data;
    logic [ratio-1:0]       merged_mask;
    logic                   c_xfer;
    logic                   completing;

    // Input is accepted whenever the output register is empty or draining,
    // so c_drdy never depends combinationally on the input side.
    assign c_drdy     = !p_srdy || p_drdy;
    assign c_xfer     = c_srdy && c_drdy;
    assign completing = (idx == last_idx) || c_last;

    // Accumulator contents with the incoming beat dropped into lane idx.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        merged_data = acc;
        merged_mask = mask;
        merged_data[sd_lane_lsb(int'(idx), width) +: width] = c_data;
        merged_mask[idx] = 1'b1;
    end

    // Accumulator: collect partial beats, clear on the completing beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: accumulator data and mask are reset too, so a reset mid-packet leaves no stale lanes.
            idx  <= '0;
            acc  <= '0;
            mask <= '0;
        end else if (c_xfer) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            if (completing) begin
                idx  <= '0;
                acc  <= '0;
                mask <= '0;
            end else begin
                idx  <= idx + lw'(1);
                acc  <= merged_data;
                mask <= merged_mask;
            end
        end
    end

    // Output register: load on a completing beat, otherwise empty on drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_srdy  <= 1'b0;
            p_data  <= '0;
            p_valid <= '0;
            p_last  <= 1'b0;
        end else if (c_xfer && completing) begin
            p_srdy  <= 1'b1;
            p_data  <= merged_data;
            p_valid <= merged_mask;
            p_last  <= c_last;
        end else if (p_drdy) begin
            p_srdy  <= 1'b0;
        end
    end

    // Upstream must hold its payload while stalled.
    a_c_data_stable: assert property (@(posedge clk) disable iff (reset)
        (c_srdy && !c_drdy) |=> (!c_srdy || $stable(c_data)));

    // A presented word always has lanes filled contiguously from lane 0.
    a_p_valid_contig: assert property (@(posedge clk) disable iff (reset)
        p_srdy |-> ((({1'b0, p_valid} + (ratio + 1)'(1)) & {1'b0, p_valid}) == '0));

endmodule
